branch_predictor_unit: RTL and testbench
========================================

Name: branch_predictor_unit

Overview:
- Parametrised dynamic branch predictor for the 32-bit RISC-V pipeline; successor to the fixed predictor behind `branch_flag`/`prediction_false_flag`.
- Fetch stage queries a table of saturating direction counters (BHT) plus a direct-mapped branch target buffer (BTB).
- Execute stage returns the resolved outcome; the block trains the tables, flags mispredicts, supplies the redirect PC and keeps statistics.
- Supports bimodal or gshare indexing.

Parameters:
- XLEN, 32, address width.
- BHT_ENTRIES, 64, direction counters; power of 2.
- BTB_ENTRIES, 16, target entries; power of 2, ≤ BHT_ENTRIES.
- CNT_BITS, 2, counter width, 1..4.
- GHR_BITS, 6, global history length; must be ≤ log2(BHT_ENTRIES).
- MODE, 0, 0 = bimodal, 1 = gshare.

Ports:
- clk  in  1  clock.
- start  in  1  asynchronous active-high reset.
- if_pc  in  XLEN  fetch PC.
- pred_taken  out  1  predicted taken.
- pred_next  out  XLEN  predicted next PC.
- pred_ghr  out  GHR_BITS  history used for this prediction; travels down the pipe.
- ex_valid  in  1  execute-stage instruction valid.
- ex_is_branch  in  1  instruction is a conditional branch/jal.
- ex_pc  in  XLEN  resolved instruction PC.
- ex_taken  in  1  actual direction.
- ex_target  in  XLEN  actual taken target.
- ex_pred_next  in  XLEN  pred_next carried with the instruction.
- ex_ghr  in  GHR_BITS  pred_ghr carried with the instruction.
- mispredict  out  1  execute outcome differs from prediction.
- redirect_pc  out  XLEN  correct next PC when mispredict.
- branch_count  out  32  resolved branches.
- mispredict_count  out  32  mispredicted instructions.

Behaviour:
- Reset (start=1, async):
  - Counters cleared to weakly-not-taken, 2^(CNT_BITS-1)-1 (01 for 2 bits).
  - All BTB valid bits cleared.
  - GHR, branch_count, mispredict_count set to 0.
  - Combinational outputs follow from the reset state: pred_taken=0, pred_next=if_pc+4, pred_ghr=0.
  - A reset mid-training discards all state; no partial update survives.
- Indexing:
  - bidx = if_pc[log2(BHT)+1:2], XORed with GHR (zero-extended) when MODE=1.
  - btb_idx = if_pc[log2(BTB)+1:2]; tag = remaining upper bits above btb_idx (bits [1:0] excluded).
- Prediction is combinational, zero-cycle, from registered state:
  - pred_taken = counter MSB AND BTB hit (valid and tag match).
  - pred_next = pred_taken ? btb_target : if_pc+4.
  - pred_ghr = current GHR.
- Resolution is combinational from ex_* inputs, active when ex_valid=1:
  - actual_next = (ex_is_branch & ex_taken) ? ex_target : ex_pc+4.
  - mispredict = (actual_next != ex_pred_next); redirect_pc = actual_next.
  - ex_valid=0 → mispredict=0, redirect_pc=0.
  - Non-branch with ex_pred_next != ex_pc+4 (BTB alias) → mispredict=1 and that BTB entry is invalidated.
- Training, on the rising clk edge, when ex_valid & ex_is_branch:
  - Counter at ex index (computed from ex_pc and ex_ghr) increments if taken, decrements if not.
  - Counter saturates at 0 and at 2^CNT_BITS-1; no wrap.
  - Taken: BTB entry written with {valid=1, tag, ex_target}, overwriting any occupant.
  - Not taken: BTB untouched.
  - GHR <= {GHR[GHR_BITS-2:0], ex_taken} (non-speculative, so no repair is needed).
  - branch_count += 1.
- mispredict_count += 1 on any cycle where mispredict=1.
- Both stats counters wrap modulo 2^32.
- Simultaneous fetch lookup and training on the same entry: the lookup returns the pre-update value. There is no bypass; the write is visible from the next cycle.
- No stalls or handshakes. The pipeline is responsible for gating ex_valid on flushed or bubbled instructions.

Decomposition:
- Package bp_pkg holds:
  - MODE_BIMODAL/MODE_GSHARE constants.
  - Counter reset/max constants derived from CNT_BITS.
  - Saturating-update function.
  - BTB entry typedef {valid, tag, target}.
- One sub-module, bp_btb: direct-mapped tag/target store with one combinational read port, one write port and an invalidate port.
- BHT, GHR and stats stay in the top.

Test Plan:
- Reset then if_pc=0x100 → pred_taken=0, pred_next=0x104, both stats 0.
- Branch at 0x100 resolved taken to 0x80 once; if_pc=0x100:
  - Counter goes 01→10, BTB fills.
  - Next cycle pred_taken=1, pred_next=0x80.
  - The resolution cycle showed mispredict=1, redirect_pc=0x80; mispredict_count=1.
- Saturation: 5 taken then 1 not-taken on the same PC:
  - Counter reads 11, then 10; prediction is still taken.
  - Two further not-taken give 00; a further not-taken stays at 00.
- Lookup and update same index same cycle → pred_taken reflects old counter; the following cycle reflects the new one.
- MODE=1, GHR_BITS=2: alternating T/N branch at 0x200 → after warm-up, 0 mispredicts over 20 iterations. MODE=0 on the same stream → mispredicts persist.
- Non-branch at 0x140 aliasing a BTB hit (ex_pred_next=0x80) → mispredict=1, redirect_pc=0x144; entry invalidated; next lookup of 0x140 → pred_next=0x144. Assert start mid-run → all tables and stats cleared immediately.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the dynamic branch predictor: indexing modes,
// saturating-counter arithmetic and the BTB entry layout.
package bp_pkg;

    localparam int unsigned MODE_BIMODAL = 0;
    localparam int unsigned MODE_GSHARE  = 1;

    localparam int unsigned CNT_MAX_BITS = 4;
    localparam int unsigned BP_XLEN      = 32;

    typedef logic [CNT_MAX_BITS-1:0] cnt_t;

    // Weakly-not-taken value for a counter of the given width
    function automatic cnt_t cnt_reset_val(input int unsigned bits);
        return cnt_t'((1 << (bits - 1)) - 1);
    endfunction

    function automatic cnt_t cnt_max_val(input int unsigned bits);
        return cnt_t'((1 << bits) - 1);
    endfunction

    // Saturating step toward the resolved direction; never wraps
    function automatic cnt_t sat_update(input cnt_t cnt, input logic taken, input cnt_t max);
        cnt_t res;
        res = cnt;
        if (taken) begin
            if (cnt != max) res = cnt + cnt_t'(1);
        end else begin
            if (cnt != cnt_t'(0)) res = cnt - cnt_t'(1);
        end
        return res;
    endfunction

    typedef struct packed {
        logic               valid;
        logic [BP_XLEN-1:0] tag;
        logic [BP_XLEN-1:0] target;
    } btb_entry_t;

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: one combinational lookup port, one
// fill port and one invalidate port. A fill wins over an invalidate.
module bp_btb
    import bp_pkg::*;
#(
    parameter  int unsigned ENTRIES = 16,
    parameter  int unsigned XLEN    = 32,
    parameter  int unsigned TAG_W   = 26,
    localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             start,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_hit_c,
    output logic [XLEN-1:0]  rd_target_c,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [XLEN-1:0]  wr_target,
    input  logic             inv_en,
    input  logic [IDX_W-1:0] inv_idx
);

    btb_entry_t mem [ENTRIES];
    btb_entry_t rd_entry;
    btb_entry_t wr_entry;

    always_comb begin
        rd_entry    = mem[rd_idx];
        rd_hit_c    = rd_entry.valid && (rd_entry.tag == BP_XLEN'(rd_tag));
        rd_target_c = XLEN'(rd_entry.target);
    end

    always_comb begin
        wr_entry        = '0;
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = BP_XLEN'(wr_tag);
        wr_entry.target = BP_XLEN'(wr_target);
    end

    always_ff @(posedge clk or posedge start) begin
        if (start) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_entry;
        end else if (inv_en) begin
            mem[inv_idx].valid <= 1'b0;
        end
    end

endmodule

// File: rtl/branch_predictor_unit.sv
// Dynamic branch predictor: saturating-counter BHT (bimodal or gshare
// indexed) plus BTB, trained non-speculatively from the execute stage.
module branch_predictor_unit
    import bp_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned BTB_ENTRIES = 16,
    parameter int unsigned CNT_BITS    = 2,
    parameter int unsigned GHR_BITS    = 6,
    parameter int unsigned MODE        = MODE_BIMODAL
) (
    input  logic                clk,
    input  logic                start,
    input  logic [XLEN-1:0]     if_pc,
    output logic                pred_taken,
    output logic [XLEN-1:0]     pred_next,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                ex_valid,
    input  logic                ex_is_branch,
    input  logic [XLEN-1:0]     ex_pc,
    input  logic                ex_taken,
    input  logic [XLEN-1:0]     ex_target,
    input  logic [XLEN-1:0]     ex_pred_next,
    input  logic [GHR_BITS-1:0] ex_ghr,
    output logic                mispredict,
    output logic [XLEN-1:0]     redirect_pc,
    output logic [31:0]         branch_count,
    output logic [31:0]         mispredict_count
);

    localparam int unsigned BIDX_W    = $clog2(BHT_ENTRIES);
    localparam int unsigned BTB_IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W     = XLEN - BTB_IDX_W - 2;

    localparam logic [CNT_BITS-1:0] CNT_RESET = CNT_BITS'(cnt_reset_val(CNT_BITS));
    localparam cnt_t                CNT_MAX   = cnt_max_val(CNT_BITS);

    logic [CNT_BITS-1:0] bht [BHT_ENTRIES];
    logic [GHR_BITS-1:0] ghr;

    logic [BIDX_W-1:0]   if_hist;
    logic [BIDX_W-1:0]   ex_hist;
    logic [BIDX_W-1:0]   if_bidx;
    logic [BIDX_W-1:0]   ex_bidx;
    logic [CNT_BITS-1:0] if_cnt;

    logic                btb_hit;
    logic [XLEN-1:0]     btb_target;
    logic                btb_wr;
    logic                btb_inv;

    logic [XLEN-1:0]     ex_seq_pc;
    logic [XLEN-1:0]     actual_next;
    logic                train;

    // History folding only applies in gshare mode; bimodal ignores it
    always_comb begin
        if_hist = '0;
        ex_hist = '0;
        if (MODE == MODE_GSHARE) begin
            if_hist = BIDX_W'(ghr);
            ex_hist = BIDX_W'(ex_ghr);
        end
        if_bidx = if_pc[BIDX_W+1:2] ^ if_hist;
        ex_bidx = ex_pc[BIDX_W+1:2] ^ ex_hist;
        if_cnt  = bht[if_bidx];
    end

    always_comb begin
        pred_taken = if_cnt[CNT_BITS-1] & btb_hit;
        pred_next  = pred_taken ? btb_target : (if_pc + XLEN'(4));
        pred_ghr   = ghr;
    end

    // Resolution compares the real successor with what fetch actually followed
    always_comb begin
        ex_seq_pc   = ex_pc + XLEN'(4);
        actual_next = (ex_is_branch & ex_taken) ? ex_target : ex_seq_pc;
        mispredict  = ex_valid & (actual_next != ex_pred_next);
        redirect_pc = ex_valid ? actual_next : '0;
        train       = ex_valid & ex_is_branch;
        btb_wr      = train & ex_taken;
        btb_inv     = ex_valid & ~ex_is_branch & (ex_pred_next != ex_seq_pc);
    end

    always_ff @(posedge clk or posedge start) begin
        if (start) begin
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= CNT_RESET;
            end
        end else if (train) begin
            bht[ex_bidx] <= CNT_BITS'(sat_update(cnt_t'(bht[ex_bidx]), ex_taken, CNT_MAX));
        end
    end

    always_ff @(posedge clk or posedge start) begin
        if (start) begin
            ghr <= '0;
        end else if (train) begin
            ghr <= GHR_BITS'({ghr, ex_taken});
        end
    end

    always_ff @(posedge clk or posedge start) begin
        if (start) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            branch_count     <= branch_count + 32'(train);
            mispredict_count <= mispredict_count + 32'(mispredict);
        end
    end

    bp_btb #(
        .ENTRIES (BTB_ENTRIES),
        .XLEN    (XLEN),
        .TAG_W   (TAG_W)
    ) u_btb (
        .clk         (clk),
        .start       (start),
        .rd_idx      (if_pc[BTB_IDX_W+1:2]),
        .rd_tag      (if_pc[XLEN-1:BTB_IDX_W+2]),
        .rd_hit_c    (btb_hit),
        .rd_target_c (btb_target),
        .wr_en       (btb_wr),
        .wr_idx      (ex_pc[BTB_IDX_W+1:2]),
        .wr_tag      (ex_pc[XLEN-1:BTB_IDX_W+2]),
        .wr_target   (ex_target),
        .inv_en      (btb_inv),
        .inv_idx     (ex_pc[BTB_IDX_W+1:2])
    );

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Scoreboard bench: a bimodal and a gshare (2-bit history) predictor share a
// one-deep fetch->execute stream; a table-level reference model predicts all outputs.
module tb_branch_predictor_unit;

    localparam int unsigned BHT = 64;
    localparam int unsigned BTB = 16;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        start;
    logic [31:0] if_pc;
    logic        ex_valid, ex_is_branch, ex_taken;
    logic [31:0] ex_pc, ex_target;
    logic [31:0] ex_pred_next0, ex_pred_next1;
    logic [5:0]  ex_ghr0;
    logic [1:0]  ex_ghr1;

    logic        pt0, pt1, mis0, mis1;
    logic [31:0] pn0, pn1, rd0, rd1, bc0, bc1, mc0, mc1;
    logic [5:0]  pg0;
    logic [1:0]  pg1;

    branch_predictor_unit u_bimodal (
        .clk(clk), .start(start), .if_pc(if_pc),
        .pred_taken(pt0), .pred_next(pn0), .pred_ghr(pg0),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
        .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_next(ex_pred_next0), .ex_ghr(ex_ghr0),
        .mispredict(mis0), .redirect_pc(rd0),
        .branch_count(bc0), .mispredict_count(mc0)
    );

    branch_predictor_unit #(.MODE(1), .GHR_BITS(2)) u_gshare (
        .clk(clk), .start(start), .if_pc(if_pc),
        .pred_taken(pt1), .pred_next(pn1), .pred_ghr(pg1),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
        .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_next(ex_pred_next1), .ex_ghr(ex_ghr1),
        .mispredict(mis1), .redirect_pc(rd1),
        .branch_count(bc1), .mispredict_count(mc1)
    );

    typedef struct {
        bit          pt;
        logic [31:0] pn;
        int unsigned pg;
        bit          mis;
        logic [31:0] rd;
        int unsigned bc;
        int unsigned mc;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        bit          valid;
        bit          br;
        bit          tk;
        logic [31:0] tgt;
        bit          force_pn;
        logic [31:0] pn_val;
    } instr_t;

    exp_t q0[$];
    exp_t q1[$];

    int total = 0;
    int bad   = 0;

    // Reference model: per-predictor tables, plain arithmetic
    int unsigned m_cnt [2][BHT];
    bit          m_v   [2][BTB];
    int unsigned m_tag [2][BTB];
    int unsigned m_tgt [2][BTB];
    int unsigned m_ghr [2];
    int unsigned m_bc  [2];
    int unsigned m_mc  [2];
    int unsigned m_mode  [2] = '{0, 1};
    int unsigned m_gbits [2] = '{6, 2};

    instr_t      ex_slot;
    logic [31:0] c_pn  [2];
    int unsigned c_ghr [2];

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < BHT; i++) m_cnt[d][i] = 1;
            for (int i = 0; i < BTB; i++) begin
                m_v[d][i] = 0; m_tag[d][i] = 0; m_tgt[d][i] = 0;
            end
            m_ghr[d] = 0; m_bc[d] = 0; m_mc[d] = 0;
        end
    endtask

    function automatic int unsigned bidx(input int d, input logic [31:0] pc, input int unsigned h);
        int unsigned base;
        base = (pc / 4) % BHT;
        return (m_mode[d] == 1) ? (base ^ h) : base;
    endfunction

    task automatic predict(input int d, input logic [31:0] pc, output bit tk, output logic [31:0] nx);
        int unsigned b;
        bit hit;
        b   = (pc / 4) % BTB;
        hit = m_v[d][b] && (m_tag[d][b] == pc / (4 * BTB));
        tk  = (m_cnt[d][bidx(d, pc, m_ghr[d])] >= 2) && hit;
        nx  = tk ? m_tgt[d][b] : pc + 32'd4;
    endtask

    task automatic train(input int d);
        logic [31:0] actual;
        int unsigned i, b;
        if (!ex_slot.valid) return;
        actual = (ex_slot.br && ex_slot.tk) ? ex_slot.tgt : ex_slot.pc + 32'd4;
        b = (ex_slot.pc / 4) % BTB;
        if (ex_slot.br) begin
            i = bidx(d, ex_slot.pc, c_ghr[d]);
            if (ex_slot.tk && m_cnt[d][i] < 3) m_cnt[d][i]++;
            if (!ex_slot.tk && m_cnt[d][i] > 0) m_cnt[d][i]--;
            if (ex_slot.tk) begin
                m_v[d][b] = 1; m_tag[d][b] = ex_slot.pc / (4 * BTB); m_tgt[d][b] = ex_slot.tgt;
            end
            m_ghr[d] = ((m_ghr[d] << 1) | int'(ex_slot.tk)) % (1 << m_gbits[d]);
            m_bc[d]++;
        end else if (c_pn[d] != ex_slot.pc + 32'd4) begin
            m_v[d][b] = 0;
        end
        if (actual != c_pn[d]) m_mc[d]++;
    endtask

    task automatic drive(input logic [31:0] pc);
        if_pc         = pc;
        ex_valid      = ex_slot.valid;
        ex_is_branch  = ex_slot.br;
        ex_pc         = ex_slot.pc;
        ex_taken      = ex_slot.tk;
        ex_target     = ex_slot.tgt;
        ex_pred_next0 = c_pn[0];
        ex_pred_next1 = c_pn[1];
        ex_ghr0       = 6'(c_ghr[0]);
        ex_ghr1       = 2'(c_ghr[1]);
    endtask

    task automatic push_exp(input int d);
        exp_t e;
        logic [31:0] actual;
        predict(d, if_pc, e.pt, e.pn);
        actual = (ex_is_branch && ex_taken) ? ex_target : ex_pc + 32'd4;
        e.pg  = m_ghr[d];
        e.mis = ex_valid && (actual != c_pn[d]);
        e.rd  = ex_valid ? actual : 32'd0;
        e.bc  = m_bc[d];
        e.mc  = m_mc[d];
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    // One cycle: fetch `cur`, resolve the previously fetched instruction
    task automatic step(input instr_t cur);
        logic [31:0] npn [2];
        int unsigned ngh [2];
        bit t;
        logic [31:0] nx;
        @(posedge clk); #1;
        start = 1'b0;
        drive(cur.pc);
        for (int d = 0; d < 2; d++) push_exp(d);
        for (int d = 0; d < 2; d++) begin
            predict(d, cur.pc, t, nx);
            npn[d] = cur.force_pn ? cur.pn_val : nx;
            ngh[d] = m_ghr[d];
        end
        for (int d = 0; d < 2; d++) train(d);
        ex_slot = cur;
        c_pn    = npn;
        c_ghr   = ngh;
        @(negedge clk);
    endtask

    // Asynchronous reset mid-cycle; any pending execute instruction is discarded
    task automatic do_reset(input logic [31:0] pc);
        @(posedge clk); #1;
        start = 1'b1;
        model_reset();
        drive(pc);
        for (int d = 0; d < 2; d++) push_exp(d);
        ex_slot.valid = 0;
        @(negedge clk);
    endtask

    function automatic instr_t mk(input logic [31:0] pc, input bit v, input bit br,
                                  input bit tk, input logic [31:0] tgt);
        instr_t r;
        r.pc = pc; r.valid = v; r.br = br; r.tk = tk; r.tgt = tgt;
        r.force_pn = 0; r.pn_val = 32'd0;
        return r;
    endfunction

    task automatic branch_once(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
        step(mk(pc, 1, 1, tk, tgt));
        step(mk(pc, 0, 0, 0, 0));
    endtask

    exp_t me;
    always @(negedge clk) begin
        if (q0.size() > 0) begin
            me = q0.pop_front();
            chk("d0_pred_taken", pt0, me.pt);
            chk("d0_pred_next", pn0, me.pn);
            chk("d0_pred_ghr", pg0, me.pg);
            chk("d0_mispredict", mis0, me.mis);
            chk("d0_redirect", rd0, me.rd);
            chk("d0_branch_count", bc0, me.bc);
            chk("d0_mispredict_count", mc0, me.mc);
        end
        if (q1.size() > 0) begin
            me = q1.pop_front();
            chk("d1_pred_taken", pt1, me.pt);
            chk("d1_pred_next", pn1, me.pn);
            chk("d1_pred_ghr", pg1, me.pg);
            chk("d1_mispredict", mis1, me.mis);
            chk("d1_redirect", rd1, me.rd);
            chk("d1_branch_count", bc1, me.bc);
            chk("d1_mispredict_count", mc1, me.mc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        instr_t r;
        logic [31:0] pool [5];
        int unsigned s0, s1;
        pool = '{32'h100, 32'h140, 32'h200, 32'h1100, 32'h104};

        start = 1'b1;
        ex_slot = mk(32'h0, 0, 0, 0, 32'h0);
        c_pn = '{32'h0, 32'h0};
        c_ghr = '{0, 0};
        model_reset();
        drive(32'h100);

        // Reset state
        do_reset(32'h100);
        chk("rst_pred_taken", pt0, 0);
        chk("rst_pred_next", pn0, 32'h104);
        chk("rst_branch_count", bc0, 0);
        chk("rst_mispredict_count", mc0, 0);

        // First taken branch: mispredict on resolve, old value on same-cycle lookup
        step(mk(32'h100, 1, 1, 1, 32'h80));
        step(mk(32'h100, 0, 0, 0, 32'h0));
        chk("first_mispredict", mis0, 1);
        chk("first_redirect", rd0, 32'h80);
        chk("same_cycle_old", pt0, 0);
        step(mk(32'h100, 0, 0, 0, 32'h0));
        chk("trained_taken", pt0, 1);
        chk("trained_next", pn0, 32'h80);
        chk("trained_mcount", mc0, 1);
        chk("trained_bcount", bc0, 1);

        // Saturation at both ends
        do_reset(32'h100);
        repeat (5) branch_once(32'h100, 1, 32'h80);
        branch_once(32'h100, 0, 32'h80);
        step(mk(32'h100, 0, 0, 0, 32'h0));
        chk("sat_top_still_taken", pt0, 1);
        repeat (2) branch_once(32'h100, 0, 32'h80);
        step(mk(32'h100, 0, 0, 0, 32'h0));
        chk("sat_down_not_taken", pt0, 0);
        branch_once(32'h100, 0, 32'h80);
        branch_once(32'h100, 1, 32'h80);
        step(mk(32'h100, 0, 0, 0, 32'h0));
        chk("sat_floor_no_wrap", pt0, 0);
        branch_once(32'h100, 1, 32'h80);
        step(mk(32'h100, 0, 0, 0, 32'h0));
        chk("sat_floor_recover", pt0, 1);

        // Alternating branch: gshare learns it, bimodal keeps missing
        do_reset(32'h200);
        for (int k = 0; k < 20; k++) branch_once(32'h200, (k % 2) == 0, 32'h300);
        s0 = mc0;
        s1 = mc1;
        for (int k = 20; k < 40; k++) branch_once(32'h200, (k % 2) == 0, 32'h300);
        step(mk(32'h200, 0, 0, 0, 32'h0));
        chk("gshare_zero_miss", mc1 - s1, 0);
        chk("bimodal_persists", (mc0 - s0) > 0, 1);

        // Non-branch aliasing a BTB hit
        do_reset(32'h100);
        branch_once(32'h100, 1, 32'h80);
        step(mk(32'h100, 0, 0, 0, 32'h0));
        chk("alias_pre_hit", pt0, 1);
        r = mk(32'h140, 1, 0, 0, 32'h0);
        r.force_pn = 1;
        r.pn_val = 32'h80;
        step(r);
        step(mk(32'h140, 0, 0, 0, 32'h0));
        chk("alias_mispredict", mis0, 1);
        chk("alias_redirect", rd0, 32'h144);
        step(mk(32'h140, 0, 0, 0, 32'h0));
        chk("alias_next_seq", pn0, 32'h144);
        step(mk(32'h100, 0, 0, 0, 32'h0));
        chk("alias_invalidated", pt0, 0);

        // Randomized mixed stream
        do_reset(32'h100);
        for (int n = 0; n < 400; n++) begin
            logic [31:0] pc;
            pc = ($urandom_range(0, 5) == 5) ? (32'($urandom_range(0, 4095)) << 2)
                                              : pool[$urandom_range(0, 4)];
            r = mk(pc, $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 1) == 1, 32'($urandom_range(0, 255)) << 2);
            if ($urandom_range(0, 15) == 0) begin
                r.force_pn = 1;
                r.pn_val = 32'($urandom_range(0, 255)) << 2;
            end
            step(r);
        end

        // Reset with a branch waiting to train
        step(mk(32'h100, 1, 1, 1, 32'h80));
        do_reset(32'h100);
        chk("midrst_bcount", bc0, 0);
        chk("midrst_mcount", mc0, 0);
        chk("midrst_ghr", pg1, 0);
        step(mk(32'h100, 0, 0, 0, 32'h0));
        chk("midrst_discard_taken", pt0, 0);
        chk("midrst_discard_next", pn0, 32'h104);
        chk("midrst_discard_bcount", bc0, 0);

        step(mk(32'h100, 0, 0, 0, 32'h0));
        @(posedge clk); #1;
        chk("queue_drained", q0.size() + q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
